// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: the FSM state
// encoding, the ALU operand forwarding select codes and a small saturating
// increment helper for the memory-wait counter.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // Controller state; the numeric values are visible on the state output.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_FLUSH   = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } hazState_t;

    // ALU operand source selects.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] satInc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Chooses the source of one ALU operand for the instruction in EX.
//   srcValid_i       - the ID/EX entry holds a real instruction
//   srcReg_i         - source register number of that operand
//   exmemValid_i / exmemRegwrite_i / exmemDest_i - producer one stage ahead
//   memwbValid_i / memwbRegwrite_i / memwbDest_i - producer two stages ahead
//   fwdSel_o         - FWD_RF, FWD_EXMEM or FWD_MEMWB
// -----------------------------------------------------------------------------
module fwd_select
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       srcValid_i,
    input  logic [4:0] srcReg_i,
    input  logic       exmemValid_i,
    input  logic       exmemRegwrite_i,
    input  logic [4:0] exmemDest_i,
    input  logic       memwbValid_i,
    input  logic       memwbRegwrite_i,
    input  logic [4:0] memwbDest_i,
    output logic [1:0] fwdSel_o
);

    // The younger producer (EX/MEM) holds the most recent value, so it wins
    // over MEM/WB. Register 0 is hard-wired and is never forwarded.
    always_comb begin
        fwdSel_o = FWD_RF;
        if (srcValid_i && (srcReg_i != 5'd0)) begin
            if (exmemValid_i && exmemRegwrite_i && (exmemDest_i == srcReg_i)) begin
                fwdSel_o = FWD_EXMEM;
            end else if (memwbValid_i && memwbRegwrite_i && (memwbDest_i == srcReg_i)) begin
                fwdSel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and forwarding controller for a five-stage pipeline. It shadows the
// ID/EX, EX/MEM and MEM/WB registers, detects data-memory waits, taken
// branches and load-use hazards, and drives the stage enables, flushes,
// bubble insertion and operand forwarding selects.
//   clock, reset (async, active low)
//   id_*             - description of the instruction currently in ID
//   mem_branch_taken - a branch resolved taken in MEM
//   dmem_ready       - data memory finished the current MEM access
//   pc_write, ifid_write, pipe_advance - stage register enables
//   flush_ifid, flush_idex, flush_exmem, idex_bubble - squash controls
//   fwd_a, fwd_b     - ALU operand source selects
//   state            - controller state, timeout_err - sticky wait timeout
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_dest,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       mem_branch_taken,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       pipe_advance,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_exmem,
    output logic       idex_bubble,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] state,
    output logic       timeout_err
);

    logic       idexValid_q, idexRegwrite_q, idexMemread_q;
    logic [4:0] idexRs_q, idexRt_q, idexDest_q;
    logic       exmemValid_q, exmemRegwrite_q, exmemMemread_q;
    logic [4:0] exmemDest_q;
    logic       memwbValid_q, memwbRegwrite_q;
    logic [4:0] memwbDest_q;

    hazState_t  state_q, state_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       timeoutErr_q;

    logic       memWait, brFlush, loadUse, srcHit;

    // Hazard events for this cycle. The branch input is gated by reset so
    // that no flush can escape while the controller is held in reset; the
    // other events already depend on tracking valids that reset clears.
    always_comb begin
        memWait = exmemValid_q && exmemMemread_q && !dmem_ready;
        brFlush = reset && mem_branch_taken;
        srcHit  = (id_use_rs && (id_rs == idexDest_q)) ||
                  (id_use_rt && (id_rt == idexDest_q));
        loadUse = id_valid && idexValid_q && idexMemread_q &&
                  (idexDest_q != 5'd0) && srcHit;
    end

    // Control outputs act in the same cycle as the event they respond to;
    // the registered state then records which response was taken.
    always_comb begin
        state_d      = ST_RUN;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        pipe_advance = 1'b1;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;
        idex_bubble  = 1'b0;
        if (memWait) begin
            state_d      = ST_MEM_WAIT;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_advance = 1'b0;
        end else if (brFlush) begin
            state_d     = ST_BR_FLUSH;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (loadUse) begin
            state_d     = ST_LOAD_STALL;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Consecutive memory-wait cycles; any cycle without a wait clears it.
    always_comb begin
        waitCnt_d = memWait ? satInc(waitCnt_q) : 8'd0;
    end

    // Shadow pipeline: shifts with pipe_advance. A bubble or flush empties
    // ID/EX, and a flush also squashes the instruction leaving EX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idexValid_q     <= 1'b0;
            idexRs_q        <= 5'd0;
            idexRt_q        <= 5'd0;
            idexDest_q      <= 5'd0;
            idexRegwrite_q  <= 1'b0;
            idexMemread_q   <= 1'b0;
            exmemValid_q    <= 1'b0;
            exmemDest_q     <= 5'd0;
            exmemRegwrite_q <= 1'b0;
            exmemMemread_q  <= 1'b0;
            memwbValid_q    <= 1'b0;
            memwbDest_q     <= 5'd0;
            memwbRegwrite_q <= 1'b0;
        end else if (pipe_advance) begin
            idexValid_q     <= id_valid && !idex_bubble && !flush_idex;
            idexRs_q        <= id_rs;
            idexRt_q        <= id_rt;
            idexDest_q      <= id_dest;
            idexRegwrite_q  <= id_regwrite;
            idexMemread_q   <= id_memread;
            exmemValid_q    <= idexValid_q && !flush_exmem;
            exmemDest_q     <= idexDest_q;
            exmemRegwrite_q <= idexRegwrite_q;
            exmemMemread_q  <= idexMemread_q;
            memwbValid_q    <= exmemValid_q;
            memwbDest_q     <= exmemDest_q;
            memwbRegwrite_q <= exmemRegwrite_q;
        end
    end

    // State, wait counter and the sticky timeout flag. The flag is set on the
    // same edge at which the counter reaches the timeout value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            waitCnt_q    <= 8'd0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (memWait && (int'(waitCnt_d) >= MEM_TIMEOUT)) begin
                timeoutErr_q <= 1'b1;
            end
        end
    end

    assign state       = state_q;
    assign timeout_err = timeoutErr_q;

    fwd_select uFwdA (
        .srcValid_i      (idexValid_q),
        .srcReg_i        (idexRs_q),
        .exmemValid_i    (exmemValid_q),
        .exmemRegwrite_i (exmemRegwrite_q),
        .exmemDest_i     (exmemDest_q),
        .memwbValid_i    (memwbValid_q),
        .memwbRegwrite_i (memwbRegwrite_q),
        .memwbDest_i     (memwbDest_q),
        .fwdSel_o        (fwd_a)
    );

    fwd_select uFwdB (
        .srcValid_i      (idexValid_q),
        .srcReg_i        (idexRt_q),
        .exmemValid_i    (exmemValid_q),
        .exmemRegwrite_i (exmemRegwrite_q),
        .exmemDest_i     (exmemDest_q),
        .memwbValid_i    (memwbValid_q),
        .memwbRegwrite_i (memwbRegwrite_q),
        .memwbDest_i     (memwbDest_q),
        .fwdSel_o        (fwd_b)
    );

endmodule
